// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch and data
//   channels. At most one transaction is in flight. Data wins arbitration
//   unless instruction fetch has waited through STARVE_MAX consecutive data
//   grants.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   inst_* / data_*      requester side: req/wr/size/addr/wdata in,
//                        addr_ok/data_ok pulses and rdata out
//   mem_*                bus side: req/wr/size/addr/wdata out,
//                        addr_ok/data_ok/rdata in
//   busy                 high while a transaction is in ADDR or WAIT
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_INST   = 1'b0;
  localparam logic       OWN_DATA   = 1'b1;

  state_t              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                grant_data_s;
  logic                grant_inst_s;

  // Data wins unless inst is pending and has been passed over STARVE_MAX times.
  assign grant_data_s = data_req && !(inst_req && (starve_cnt_q >= STARVE_LIM));
  assign grant_inst_s = inst_req && !grant_data_s;

  // Next-state, transaction capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = 1'b0;

    // Outputs are forced quiet while reset is held, even if the state
    // register has not yet returned to IDLE.
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (grant_data_s) begin
            data_addr_ok = 1'b1;
            owner_d      = OWN_DATA;
            wr_d         = data_wr;
            size_d       = data_size;
            addr_d       = data_addr;
            wdata_d      = data_wdata;
            state_d      = ST_ADDR;
            if (inst_req) begin
              if (starve_cnt_q != 4'd15) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
              end else begin
                starve_cnt_d = starve_cnt_q;
              end
            end else begin
              starve_cnt_d = 4'd0;
            end
          end else if (grant_inst_s) begin
            inst_addr_ok = 1'b1;
            owner_d      = OWN_INST;
            wr_d         = inst_wr;
            size_d       = inst_size;
            addr_d       = inst_addr;
            wdata_d      = inst_wdata;
            state_d      = ST_ADDR;
            starve_cnt_d = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR: begin
          // mem_data_ok is deliberately ignored until the address is taken.
          mem_req   = 1'b1;
          mem_wr    = wr_q;
          mem_size  = size_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          if (mem_addr_ok) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_WAIT: begin
          if (mem_data_ok) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_DATA) begin
              data_data_ok = 1'b1;
              data_rdata   = mem_rdata;
            end else begin
              inst_data_ok = 1'b1;
              inst_rdata   = mem_rdata;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, starvation counter and transaction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      owner_q      <= OWN_INST;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SM = 2;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // memory model / manual override
  logic        man, man_aok, man_dok;
  logic [31:0] man_rdata;
  logic        mdl_aok, mdl_dok;
  logic [31:0] mdl_rdata;
  int          addr_dly, data_dly;

  assign mem_addr_ok = man ? man_aok : mdl_aok;
  assign mem_data_ok = man ? man_dok : mdl_dok;
  assign mem_rdata   = man ? man_rdata : mdl_rdata;

  typedef struct {
    bit          ch;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
  } txn_t;

  txn_t sb[$];
  bit   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   dok_data_cnt = 0;
  int   m_cnt = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'h23DD_0001;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory responder with configurable address/data phase delays.
  always begin : mem_model
    int   phase;
    int   cnt;
    logic [31:0] cap;
    @(posedge clk);
    #1;
    mdl_aok = 1'b0;
    mdl_dok = 1'b0;
    if (rst || man) begin
      phase = 0;
      cnt   = 0;
    end else if (phase == 0 && mem_req) begin
      if (cnt >= addr_dly) begin
        mdl_aok = 1'b1; cap = mem_addr; phase = 1; cnt = 0;
      end else cnt++;
    end else if (phase == 1) begin
      if (cnt >= data_dly) begin
        mdl_dok = 1'b1; mdl_rdata = rd_of(cap); phase = 0; cnt = 0;
      end else cnt++;
    end
  end

  // Scoreboard monitor: predicts grants, checks bus fields and completions.
  always @(negedge clk) begin : monitor
    bit   exp_d;
    txn_t it;
    if (rst) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      check_eq("busy", 64'(busy), 64'(sb.size() != 0));
      if (sb.size() == 0)
        check_eq("idle_mem_zero", 64'(|{mem_req, mem_wr, mem_size, mem_addr, mem_wdata}), 64'd0);
      if (inst_addr_ok || data_addr_ok) begin
        exp_d = data_req && !(inst_req && m_cnt >= SM);
        check_eq("grant_ch", 64'(data_addr_ok), 64'(exp_d));
        check_eq("dual_grant", 64'(inst_addr_ok & data_addr_ok), 64'd0);
        check_eq("grant_in_flight", 64'(sb.size()), 64'd0);
        if (exp_d) m_cnt = inst_req ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
        else       m_cnt = 0;
        it.ch   = exp_d;
        it.wr   = exp_d ? data_wr    : inst_wr;
        it.sz   = exp_d ? data_size  : inst_size;
        it.addr = exp_d ? data_addr  : inst_addr;
        it.wd   = exp_d ? data_wdata : inst_wdata;
        sb.push_back(it);
        grant_log.push_back(data_addr_ok);
      end
      if (mem_req) begin
        if (sb.size() == 0) check_eq("mem_req_no_txn", 64'd1, 64'd0);
        else begin
          check_eq("mem_addr", 64'(mem_addr), 64'(sb[0].addr));
          check_eq("mem_wdata", 64'(mem_wdata), 64'(sb[0].wd));
          check_eq("mem_wr_size", 64'({mem_wr, mem_size}), 64'({sb[0].wr, sb[0].sz}));
        end
      end
      if (data_data_ok) dok_data_cnt++;
      if (inst_data_ok || data_data_ok) begin
        if (sb.size() == 0) check_eq("spurious_data_ok", 64'd1, 64'd0);
        else begin
          it = sb.pop_front();
          check_eq("dok_ch", 64'(data_data_ok), 64'(it.ch));
          check_eq("dual_dok", 64'(inst_data_ok & data_data_ok), 64'd0);
          check_eq("rdata", 64'(it.ch ? data_rdata : inst_rdata), 64'(rd_of(it.addr)));
        end
      end
    end
  end

  task automatic run_req(input bit ch, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
    bit ok = 1'b0;
    lat = -1;
    rd  = 32'd0;
    if (ch) begin
      data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd; data_req = 1'b1;
    end else begin
      inst_wr = wr; inst_size = sz; inst_addr = a; inst_wdata = wd; inst_req = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ch ? data_addr_ok : inst_addr_ok) begin ok = 1'b1; break; end
    end
    check_eq("addr_ok_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    if (ch) data_req = 1'b0; else inst_req = 1'b0;
    if (ok) begin
      for (int i = 1; i < 60; i++) begin
        @(negedge clk);
        if (ch ? data_data_ok : inst_data_ok) begin
          lat = i; rd = ch ? data_rdata : inst_rdata; break;
        end
      end
      check_eq("data_ok_timeout", 64'(lat != -1), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("outs_zero_in_rst", 64'(|{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok,
             data_data_ok, data_rdata, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, busy}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : main
    int          lat, lat2, base, d0;
    logic [31:0] rd, rd2;
    bit          exp_seq [6];
    rst = 1'b1; man = 1'b0; man_aok = 1'b0; man_dok = 1'b0; man_rdata = 32'd0;
    mdl_aok = 1'b0; mdl_dok = 1'b0; mdl_rdata = 32'd0; addr_dly = 0; data_dly = 0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    do_reset();
    @(negedge clk);
    check_eq("outs_zero_after_rst", 64'(|{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok,
             data_data_ok, data_rdata, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, busy}), 64'd0);
    @(posedge clk); #1;

    // single inst read, minimum latency
    run_req(1'b0, 1'b0, 2'd2, 32'h1FC0_0000, 32'd0, lat, rd);
    check_eq("t1_latency", 64'(lat), 64'd2);
    check_eq("t1_rdata", 64'(rd), 64'h3C1D_0001);

    // data byte write with address-phase stall
    addr_dly = 3;
    d0 = dok_data_cnt;
    run_req(1'b1, 1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB, lat, rd);
    check_eq("t2_latency", 64'(lat), 64'd5);
    repeat (4) @(negedge clk);
    check_eq("t2_data_ok_once", 64'(dok_data_cnt - d0), 64'd1);

    // data-phase delay, then an inst half write (wr forwarded)
    addr_dly = 1; data_dly = 2;
    run_req(1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'd0, lat, rd);
    check_eq("t3_latency", 64'(lat), 64'd5);
    addr_dly = 0; data_dly = 0;
    @(posedge clk); #1;
    run_req(1'b0, 1'b1, 2'd1, 32'h0000_0ABE, 32'h1234_5678, lat, rd);
    check_eq("t3b_latency", 64'(lat), 64'd2);

    // simultaneous from reset: data first, inst next
    do_reset();
    base = grant_log.size();
    fork
      run_req(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0, lat, rd);
      run_req(1'b0, 1'b0, 2'd2, 32'h1FC0_0004, 32'd0, lat2, rd2);
    join
    check_eq("t4_grants", 64'(grant_log.size() - base), 64'd2);
    if (grant_log.size() >= base + 2) begin
      check_eq("t4_first_data", 64'(grant_log[base]), 64'd1);
      check_eq("t4_second_inst", 64'(grant_log[base + 1]), 64'd0);
    end

    // starvation: both held, expect D D I D D I
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(posedge clk); #1;
    base = grant_log.size();
    inst_addr = 32'h1FC0_0040; inst_wr = 1'b0; inst_size = 2'd2;
    data_addr = 32'h0000_2000; data_wr = 1'b0; data_size = 2'd2;
    inst_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant_log.size() >= base + 6) break;
    end
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    check_eq("t5_grant_count", 64'(grant_log.size() - base), 64'd6);
    if (grant_log.size() >= base + 6)
      for (int i = 0; i < 6; i++)
        check_eq($sformatf("t5_grant_%0d", i), 64'(grant_log[base + i]), 64'(exp_seq[i]));
    repeat (8) @(negedge clk);
    check_eq("t5_drained", 64'(sb.size()), 64'd0);

    // protocol violation: mem_data_ok during ADDR is ignored
    @(posedge clk); #1;
    man = 1'b1;
    inst_addr = 32'h0040_0000; inst_wr = 1'b0; inst_size = 2'd2; inst_req = 1'b1;
    @(negedge clk);
    check_eq("t6_addr_ok", 64'(inst_addr_ok), 64'd1);
    @(posedge clk); #1;
    inst_req = 1'b0; man_dok = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("t6_no_dok_in_addr", 64'(inst_data_ok), 64'd0);
    @(posedge clk); #1;
    man_dok = 1'b0;
    @(negedge clk);
    check_eq("t6_still_addr", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    man_aok = 1'b1;
    @(posedge clk); #1;
    man_aok = 1'b0; man_dok = 1'b1; man_rdata = rd_of(32'h0040_0000);
    @(negedge clk);
    check_eq("t6_dok", 64'(inst_data_ok), 64'd1);
    @(posedge clk); #1;
    man_dok = 1'b0;

    // reset during WAIT, then stale mem_data_ok
    data_addr = 32'h0000_3000; data_wr = 1'b0; data_size = 2'd2; data_req = 1'b1;
    @(negedge clk);
    check_eq("t7_addr_ok", 64'(data_addr_ok), 64'd1);
    @(posedge clk); #1;
    data_req = 1'b0; man_aok = 1'b1;
    @(posedge clk); #1;
    man_aok = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("t7_no_dok_in_rst", 64'(data_data_ok), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; man_dok = 1'b1; man_rdata = rd_of(32'h0000_3000);
    @(negedge clk);
    check_eq("t7_stale_ignored", 64'(data_data_ok | inst_data_ok), 64'd0);
    check_eq("t7_outs_zero", 64'(|{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok,
             data_data_ok, data_rdata, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, busy}), 64'd0);
    @(posedge clk); #1;
    man_dok = 1'b0; man = 1'b0;

    // normal traffic after recovery
    run_req(1'b1, 1'b0, 2'd2, 32'h0000_4004, 32'd0, lat, rd);
    check_eq("t8_latency", 64'(lat), 64'd2);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
